// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path: request record and winner source tag.
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LSU,
    SRC_FIFO,
    SRC_ALU
  } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of writeback requests; DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_data,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges LSU and ALU results onto the single regfile write port (LSU first, bounded by a starve counter).
// Optional forwarding compare is built when REGFILE_BYPASS_EN is defined.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wd
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] fwd_rs1,
  input  logic [REG_AW-1:0] fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wb_req_t       fifo_head;
  wb_req_t       alu_req;
  wb_req_t       win;
  wb_src_e       src;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          lsu_fire;
  logic          alu_fire;
  logic [SW-1:0] starve_cnt;

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;

  // Ready depends only on registered state: a full FIFO refuses even when it pops this cycle.
  assign alu_ready = (fifo_count < DEPTH_C);
  assign lsu_ready = !((starve_cnt == STARVE_LIM) && !fifo_empty);
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign alu_fire  = alu_valid && alu_ready;

  always_comb begin
    src = SRC_NONE;
    win = '0;
    if (lsu_fire) begin
      src      = SRC_LSU;
      win.rd   = lsu_rd;
      win.data = lsu_data;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
      win = fifo_head;
    end else if (alu_valid) begin
      src = SRC_ALU;
      win = alu_req;
    end
  end

  // ALU results bypass the FIFO only when it is empty, so write order is preserved.
  assign fifo_push = alu_fire && (src != SRC_ALU);
  assign fifo_pop  = (src == SRC_FIFO);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (alu_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
    end else if ((src == SRC_LSU) && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A winner addressed to x0 is consumed without raising the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= (src != SRC_NONE) && (win.rd != '0);
      rf_rd <= win.rd;
      rf_wd <= win.data;
    end
  end

  full_matches_count: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == DEPTH_C));

`ifdef REGFILE_BYPASS_EN
  assign fwd_hit1  = rf_we && (rf_rd == fwd_rs1) && (fwd_rs1 != '0);
  assign fwd_hit2  = rf_we && (rf_rd == fwd_rs2) && (fwd_rs2 != '0);
  assign fwd_data1 = fwd_hit1 ? rf_wd : '0;
  assign fwd_data2 = fwd_hit2 ? rf_wd : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes queued at stimulus time, popped by a monitor.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
`ifdef REGFILE_BYPASS_EN
  logic [4:0]  fwd_rs1;
  logic [4:0]  fwd_rs2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd)
`ifdef REGFILE_BYPASS_EN
    ,
    .fwd_rs1   (fwd_rs1),
    .fwd_rs2   (fwd_rs2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, exp_q size %0d", exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_rd    = '0;
    lsu_data  = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data);
    lsu_valid = 1'b1;
    lsu_rd    = rd;
    lsu_data  = data;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every regfile write must match the head of the expected queue
  always @(negedge clk) begin
    logic [36:0] e;
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d wd=0x%08h, expected no write", rf_rd, rf_wd);
      end else begin
        e = exp_q.pop_front();
        if ({rf_rd, rf_wd} !== e) begin
          errors++;
          $display("FAIL write_order: got rd=%0d wd=0x%08h, expected rd=%0d wd=0x%08h",
                   rf_rd, rf_wd, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
`ifdef REGFILE_BYPASS_EN
    fwd_rs1 = '0;
    fwd_rs2 = '0;
`endif
    repeat (3) cycle();

    // reset state
    check("reset_rf_we", {31'd0, rf_we}, 32'd0);
    check("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
    check("reset_rf_wd", rf_wd, 32'd0);
    check("reset_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("reset_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    rst = 1'b0;
    cycle();

    // 1: ALU cut-through with empty FIFO, one-cycle latency
    drive_alu(5'd5, 32'hA5A5_A5A5);
    check("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
    expect_write(5'd5, 32'hA5A5_A5A5);
    cycle();
    idle();
    check("t1_rf_we", {31'd0, rf_we}, 32'd1);
    check("t1_rf_wd", rf_wd, 32'hA5A5_A5A5);
    cycle();
    check("t1_rf_we_drop", {31'd0, rf_we}, 32'd0);

    // 2: LSU and ALU together; LSU first, ALU from FIFO the cycle after
    drive_lsu(5'd3, 32'h11);
    drive_alu(5'd4, 32'h22);
    expect_write(5'd3, 32'h11);
    expect_write(5'd4, 32'h22);
    cycle();
    idle();
    check("t2_first_rd", {27'd0, rf_rd}, 32'd3);
    cycle();
    check("t2_second_rd", {27'd0, rf_rd}, 32'd4);
    check("t2_second_we", {31'd0, rf_we}, 32'd1);
    repeat (2) cycle();

    // 3: continuous LSU traffic with one queued ALU entry
    for (int i = 0; i < 4; i++) begin
      drive_lsu(5'(10 + i), 32'h100 + i);
      if (i == 0) drive_alu(5'd15, 32'h150);
      else        alu_valid = 1'b0;
      check($sformatf("t3_lsu_ready_%0d", i), {31'd0, lsu_ready}, 32'd1);
      expect_write(5'(10 + i), 32'h100 + i);
      cycle();
    end
    drive_lsu(5'd14, 32'h104);
    check("t3_lsu_blocked", {31'd0, lsu_ready}, 32'd0);
    expect_write(5'd15, 32'h150);
    cycle();
    check("t3_lsu_ready_again", {31'd0, lsu_ready}, 32'd1);
    expect_write(5'd14, 32'h104);
    cycle();
    idle();
    repeat (2) cycle();

    // 4: fill the FIFO behind saturating LSU traffic, then drain in push order
    for (int i = 0; i < 4; i++) begin
      drive_lsu(5'(20 + i), 32'h200 + i);
      drive_alu(5'(24 + i), 32'h300 + i);
      check($sformatf("t4_alu_ready_%0d", i), {31'd0, alu_ready}, 32'd1);
      expect_write(5'(20 + i), 32'h200 + i);
      cycle();
    end
    drive_lsu(5'd19, 32'h2FF);
    drive_alu(5'd28, 32'h3FF);
    check("t4_alu_full", {31'd0, alu_ready}, 32'd0);
    check("t4_lsu_starved", {31'd0, lsu_ready}, 32'd0);
    for (int i = 0; i < 4; i++) expect_write(5'(24 + i), 32'h300 + i);
    cycle();
    idle();
    repeat (5) cycle();
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // 5a: write to x0 is consumed silently
    drive_alu(5'd0, 32'h77);
    check("t5_x0_ready", {31'd0, alu_ready}, 32'd1);
    cycle();
    idle();
    check("t5_x0_no_we", {31'd0, rf_we}, 32'd0);
    cycle();

    // 5b: reset with two entries queued discards them
    drive_lsu(5'd1, 32'h501);
    drive_alu(5'd2, 32'h601);
    expect_write(5'd1, 32'h501);
    cycle();
    drive_lsu(5'd3, 32'h503);
    drive_alu(5'd4, 32'h604);
    expect_write(5'd3, 32'h503);
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    check("t5_rst_we", {31'd0, rf_we}, 32'd0);
    check("t5_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    rst = 1'b0;
    cycle();
    check("t5_post_rst_we", {31'd0, rf_we}, 32'd0);
    cycle();
    check("t5_post_rst_we2", {31'd0, rf_we}, 32'd0);

`ifdef REGFILE_BYPASS_EN
    // 6: forwarding compare on the in-flight write
    drive_alu(5'd7, 32'hDEAD);
    expect_write(5'd7, 32'hDEAD);
    cycle();
    idle();
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd0;
    #1;
    check("t6_hit1", {31'd0, fwd_hit1}, 32'd1);
    check("t6_data1", fwd_data1, 32'hDEAD);
    check("t6_hit2", {31'd0, fwd_hit2}, 32'd0);
    check("t6_data2", fwd_data2, 32'd0);
    cycle();
`endif

    repeat (3) cycle();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
